tmp_seq_ctrl: RTL and testbench
===============================

Name: tmp_seq_ctrl

Overview:
Parametrised, multi-channel sequencer for the switched-capacitor temperature-sensor front end. It generates non-overlapping diode, big-diode and charge-transfer phases, plus precharge, bias-setup, source/sink chopping and comparator clocks. It scans a configurable set of sensor channels and returns a per-channel digital result through a valid strobe. It replaces the fixed single-channel controller and adds start/idle control, channel scanning, programmable phase lengths and result accumulation.

Parameters:
N_CH, 4, number of sensor channels (1..16)
CNT_W, 6, width of phase counters and of result
PRECHG_CYC, 11, PRECHARGE length in cycles (>=1)
DIODE_CYC, 1, DIODE length in cycles (>=1)
BIGDIODE_CYC, 5, cycles per BIGDIODE pass before decision (>=1)
SETUP_CYC, 6, cmp-low BIGDIODE cycles needed to finish bias setup (>=1)
OUT_CYC, 63, OUTPUT length in cycles (>=1, <2^CNT_W)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin a scan (level-sampled, ignored while busy)
cont  in  1  1 = wrap and rescan continuously, 0 = stop after last enabled channel
ch_en  in  N_CH  channel enable mask
cmp  in  1  comparator decision
PI1, PI2, PII1, PII2  out  1 each  big-diode / diode phase switches
PA, PB, PC, PD  out  1 each  charge-transfer switches
src_n, snk  out  1 each  chopped source/sink enables
cmp_p1, cmp_p2  out  1 each  complementary comparator clocks
preChrg, setupBias  out  1 each  precharge and bias-setup enables
ch_onehot  out  N_CH  active channel select
busy  out  1  high in any state except IDLE
result  out  CNT_W  last conversion value
result_ch  out  clog2(N_CH) (min 1)  channel index of result
valid  out  1  one-cycle strobe when result and result_ch update

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0 except cmp_p2=1; counters, Hcharged, Lcharged, setup_done, ones_cnt cleared. A reset mid-operation aborts immediately and discards any partial result.
- cmp_p1/cmp_p2: toggle every clk from reset release regardless of state; always complementary.
- IDLE: all switches 0. start=1 and ch_en!=0 -> PRECHARGE, ch = lowest enabled index, setup_done=0. start with ch_en=0 -> stay IDLE.
- PRECHARGE: preChrg=1, setupBias=1, PB=PC=PD=1, PA=0, PI*/PII* 0. After exactly PRECHG_CYC cycles -> BLANK_D.
- BLANK_D / BLANK_BD: exactly 1 cycle. PA..PD, PI1, PI2, PII1, PII2, preChrg all 0. These give the non-overlap gap. Each blank state carries a target; the default target is DIODE for BLANK_D and BIGDIODE for BLANK_BD.
- DIODE: PII1=PII2=1 for DIODE_CYC cycles -> BLANK_BD.
- BIGDIODE: PI1=PI2=1. Each cycle: cmp=1 toggles src_n and increments ones_cnt (saturating at 2^CNT_W-1); cmp=0 toggles snk. While setup_done=0, cmp=0 cycles increment setup_cnt; on reaching SETUP_CYC, setup_done=1 and setupBias=0 the next cycle. After BIGDIODE_CYC cycles, decide from the current cmp:
  - setup_done=0 -> BLANK_D (diode loop repeats).
  - cmp=1 and !Hcharged -> BLANK_BD with target HCHARGE.
  - cmp=0 and !Lcharged -> BLANK_BD with target LCHARGE.
  - otherwise stay in BIGDIODE, keep chopping, and re-evaluate every cycle.
- HCHARGE: 1 cycle, PA=PB=1, Hcharged=1. If Lcharged -> OUTPUT, else -> BLANK_BD.
- LCHARGE: 1 cycle, PA=PC=1, Lcharged=1. If Hcharged -> OUTPUT, else -> BLANK_BD.
- OUTPUT: PA=PB=PC=PD=1 for OUT_CYC cycles; Hcharged and Lcharged cleared. On the last cycle: result<=ones_cnt, result_ch<=ch, valid=1 for one cycle, ones_cnt<=0.
- Channel advance: the next enabled index above ch, using ch_en sampled on the last OUTPUT cycle.
  - If one exists -> BLANK_D on that channel, with no precharge and setup retained.
  - If none remain and cont=1 -> wrap to the lowest enabled channel.
  - If none remain and cont=0, or ch_en=0 -> IDLE.
- ch_onehot equals 1<<ch outside IDLE and is 0 in IDLE.
- valid has no backpressure. A result not consumed in the valid cycle is overwritten by the next one.
- All counters are CNT_W wide and compare against parameters with >=, so an out-of-range count never locks up.

Optional Feature:
CMP_SYNC_EN. When defined, cmp passes through a two-flop synchroniser (reset 0) before any use, adding 2 cycles of decision latency. When undefined, cmp is used directly and is assumed synchronous to clk.

Test Plan:
- reset=0 for 3 cycles mid-BIGDIODE -> all outputs 0 except cmp_p2=1, busy=0. On release, cmp_p1/cmp_p2 toggle each cycle and stay complementary.
- Defaults, ch_en=4'b0001, start pulse, cmp=0 -> preChrg high exactly 11 cycles; then BLANK_D, 1-cycle DIODE, BLANK_BD; setupBias drops after the 6th cmp-low BIGDIODE cycle.
- Same run with cmp alternating on each BIGDIODE decision -> HCHARGE and LCHARGE each visited once. OUTPUT lasts 63 cycles, then valid=1 for one cycle with result equal to the counted cmp-high cycles and result_ch=0.
- ch_en=4'b1010, cont=0 -> ch_onehot 0010 then 1000; two valid strobes with result_ch 1 then 3; then IDLE with busy=0.
- ch_en=4'b0101, cont=1 -> scan order 0, 2, 0, 2 with no PRECHARGE after the first. Clearing ch_en during OUTPUT -> IDLE after that valid.
- cmp held 1 for more than 2^CNT_W BIGDIODE cycles -> result saturates at 63. With CMP_SYNC_EN, decisions lag cmp by 2 cycles.

Source files
------------

// File: rtl/tmp_seq_ctrl.sv
// rtl/tmp_seq_ctrl.sv - multi-channel switched-capacitor temperature-sensor phase sequencer
// Optional build macro CMP_SYNC_EN: route cmp through a two-flop synchroniser before use.
module tmp_seq_ctrl #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 6,
  parameter int PRECHG_CYC   = 11,
  parameter int DIODE_CYC    = 1,
  parameter int BIGDIODE_CYC = 5,
  parameter int SETUP_CYC    = 6,
  parameter int OUT_CYC      = 63,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             cmp,
  output logic             PI1,
  output logic             PI2,
  output logic             PII1,
  output logic             PII2,
  output logic             PA,
  output logic             PB,
  output logic             PC,
  output logic             PD,
  output logic             src_n,
  output logic             snk,
  output logic             cmp_p1,
  output logic             cmp_p2,
  output logic             preChrg,
  output logic             setupBias,
  output logic [N_CH-1:0]  ch_onehot,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             valid
);

  typedef enum logic [3:0] {
    IDLE, PRECHARGE, BLANK_D, BLANK_BD, DIODE, BIGDIODE, HCHARGE, LCHARGE, OUTPUT
  } state_t;

  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRECHG_CYC - 1);
  localparam logic [CNT_W-1:0] DIO_LAST   = CNT_W'(DIODE_CYC - 1);
  localparam logic [CNT_W-1:0] BD_LAST    = CNT_W'(BIGDIODE_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(OUT_CYC - 1);

  state_t             state_q, state_d, tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, setup_cnt_q, setup_cnt_d, ones_q, ones_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic [CH_W-1:0]    ch_q, ch_d, result_ch_q, result_ch_d;
  logic               setup_done_q, setup_done_d, hchg_q, hchg_d, lchg_q, lchg_d;
  logic               valid_q, valid_d, src_n_q, src_n_d, snk_q, snk_d, cmp_p1_q, cmp_p1_d;
  logic [CH_W-1:0]    nxt_ch, low_ch;
  logic               nxt_ok, any_en, cmp_i;

`ifdef CMP_SYNC_EN
  logic cmp_meta_q, cmp_sync_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_meta_q <= 1'b0;
      cmp_sync_q <= 1'b0;
    end else begin
      cmp_meta_q <= cmp;
      cmp_sync_q <= cmp_meta_q;
    end
  end
  assign cmp_i = cmp_sync_q;
`else
  assign cmp_i = cmp;
`endif

  // Lowest enabled channel, and the nearest enabled channel above the current one.
  always_comb begin
    nxt_ch = ch_q;
    low_ch = '0;
    nxt_ok = 1'b0;
    any_en = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        low_ch = CH_W'(i);
        any_en = 1'b1;
        if (i > int'(ch_q)) begin
          nxt_ch = CH_W'(i);
          nxt_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    setup_cnt_d  = setup_cnt_q;
    setup_done_d = setup_done_q;
    hchg_d       = hchg_q;
    lchg_d       = lchg_q;
    ones_d       = ones_q;
    ch_d         = ch_q;
    result_d     = result_q;
    result_ch_d  = result_ch_q;
    valid_d      = 1'b0;
    src_n_d      = src_n_q;
    snk_d        = snk_q;
    cmp_p1_d     = ~cmp_p1_q;
    case (state_q)
      IDLE: begin
        if (start && any_en) begin
          state_d      = PRECHARGE;
          ch_d         = low_ch;
          setup_done_d = 1'b0;
          setup_cnt_d  = '0;
          hchg_d       = 1'b0;
          lchg_d       = 1'b0;
          ones_d       = '0;
        end
      end
      PRECHARGE: begin
        if (cnt_q >= PRE_LAST) begin
          state_d = BLANK_D;
          tgt_d   = DIODE;
        end
      end
      BLANK_D, BLANK_BD: state_d = tgt_q;
      DIODE: begin
        if (cnt_q >= DIO_LAST) begin
          state_d = BLANK_BD;
          tgt_d   = BIGDIODE;
        end
      end
      BIGDIODE: begin
        if (cmp_i) begin
          src_n_d = ~src_n_q;
          if (ones_q != '1) ones_d = ones_q + CNT_W'(1);
        end else begin
          snk_d = ~snk_q;
          if (!setup_done_q) begin
            if (setup_cnt_q != '1) setup_cnt_d = setup_cnt_q + CNT_W'(1);
            if (setup_cnt_q >= SETUP_LAST) setup_done_d = 1'b1;
          end
        end
        if (cnt_q >= BD_LAST) begin
          if (!setup_done_q) begin
            state_d = BLANK_D;
            tgt_d   = DIODE;
          end else if (cmp_i && !hchg_q) begin
            state_d = BLANK_BD;
            tgt_d   = HCHARGE;
          end else if (!cmp_i && !lchg_q) begin
            state_d = BLANK_BD;
            tgt_d   = LCHARGE;
          end
        end
      end
      HCHARGE: begin
        hchg_d  = 1'b1;
        state_d = lchg_q ? OUTPUT : BLANK_BD;
        tgt_d   = BIGDIODE;
      end
      LCHARGE: begin
        lchg_d  = 1'b1;
        state_d = hchg_q ? OUTPUT : BLANK_BD;
        tgt_d   = BIGDIODE;
      end
      OUTPUT: begin
        hchg_d = 1'b0;
        lchg_d = 1'b0;
        if (cnt_q >= OUT_LAST) begin
          result_d    = ones_q;
          result_ch_d = ch_q;
          valid_d     = 1'b1;
          ones_d      = '0;
          tgt_d       = DIODE;
          if (nxt_ok) begin
            ch_d    = nxt_ch;
            state_d = BLANK_D;
          end else if (cont && any_en) begin
            ch_d    = low_ch;
            state_d = BLANK_D;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      src_n_d = 1'b0;
      snk_d   = 1'b0;
    end
    // Phase counter restarts on every state change and saturates while a state lingers.
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tgt_q        <= DIODE;
      cnt_q        <= '0;
      setup_cnt_q  <= '0;
      setup_done_q <= 1'b0;
      hchg_q       <= 1'b0;
      lchg_q       <= 1'b0;
      ones_q       <= '0;
      ch_q         <= '0;
      result_q     <= '0;
      result_ch_q  <= '0;
      valid_q      <= 1'b0;
      src_n_q      <= 1'b0;
      snk_q        <= 1'b0;
      cmp_p1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      setup_cnt_q  <= setup_cnt_d;
      setup_done_q <= setup_done_d;
      hchg_q       <= hchg_d;
      lchg_q       <= lchg_d;
      ones_q       <= ones_d;
      ch_q         <= ch_d;
      result_q     <= result_d;
      result_ch_q  <= result_ch_d;
      valid_q      <= valid_d;
      src_n_q      <= src_n_d;
      snk_q        <= snk_d;
      cmp_p1_q     <= cmp_p1_d;
    end
  end

  always_comb begin
    {PI1, PI2, PII1, PII2, PA, PB, PC, PD, preChrg} = '0;
    case (state_q)
      PRECHARGE: {preChrg, PB, PC, PD} = 4'b1111;
      DIODE:     {PII1, PII2}          = 2'b11;
      BIGDIODE:  {PI1, PI2}            = 2'b11;
      HCHARGE:   {PA, PB}              = 2'b11;
      LCHARGE:   {PA, PC}              = 2'b11;
      OUTPUT:    {PA, PB, PC, PD}      = 4'b1111;
      default:   ;
    endcase
    busy      = (state_q != IDLE);
    setupBias = busy && !setup_done_q;
    ch_onehot = '0;
    if (busy) ch_onehot[ch_q] = 1'b1;
  end

  assign src_n     = src_n_q;
  assign snk       = snk_q;
  assign cmp_p1    = cmp_p1_q;
  assign cmp_p2    = ~cmp_p1_q;
  assign result    = result_q;
  assign result_ch = result_ch_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_tmp_seq_ctrl.sv
// tb/tb_tmp_seq_ctrl.sv - scoreboard bench for tmp_seq_ctrl (default build)
module tb_tmp_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, cont, cmp;
  logic [3:0] ch_en;
  logic       PI1, PI2, PII1, PII2, PA, PB, PC, PD, src_n, snk, cmp_p1, cmp_p2;
  logic       preChrg, setupBias, busy, valid;
  logic [3:0] ch_onehot;
  logic [5:0] result;
  logic [1:0] result_ch;

  tmp_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .ch_en(ch_en), .cmp(cmp),
    .PI1(PI1), .PI2(PI2), .PII1(PII1), .PII2(PII2), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
    .src_n(src_n), .snk(snk), .cmp_p1(cmp_p1), .cmp_p2(cmp_p2), .preChrg(preChrg),
    .setupBias(setupBias), .ch_onehot(ch_onehot), .busy(busy), .result(result),
    .result_ch(result_ch), .valid(valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_res[$];
  int exp_ch[$];
  int oh_log[$];
  int n_valid = 0;
  int prechg_cyc = 0, diode_cyc = 0, hch_cyc = 0, lch_cyc = 0, out_cyc = 0, sb_bd_cyc = 0;
  int k = 0, first = 0, in_out = 0, mode = 0, base = 1;
  int p0, d0, h0, l0, o0, s0, v0, lo, nh, prev;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    oh_idx = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) oh_idx = i;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget);
    int c = 0;
    while (n_valid < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("valid_count", n_valid, target);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("busy_end", int'(busy), 0);
  endtask

  task automatic snap();
    p0 = prechg_cyc; d0 = diode_cyc; h0 = hch_cyc; l0 = lch_cyc;
    o0 = out_cyc; s0 = sb_bd_cyc; v0 = n_valid;
    oh_log.delete();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cont = 1'b0; ch_en = 4'b0000; cmp = 1'b0;
    fork
      // Phase statistics plus the cmp stimulus: cmp depends on the BIGDIODE cycle index k.
      forever begin
        @(negedge clk);
        if (preChrg) begin prechg_cyc++; first = 1; k = 0; end
        if (PII1) diode_cyc++;
        if (PA && PB && !PC && !PD) hch_cyc++;
        if (PA && PC && !PB && !PD) lch_cyc++;
        if (PA && PB && PC && PD) begin
          out_cyc++;
          if (!in_out) oh_log.push_back(int'(ch_onehot));
          in_out = 1; k = 0; first = 0;
        end else in_out = 0;
        if (PI1) begin
          k++;
          if (setupBias) sb_bd_cyc++;
          if (mode == 1) cmp = (k >= 7 && k < 87);
          else begin
            lo = first ? 10 : 5;
            nh = base + oh_idx(ch_onehot);
            cmp = (k >= lo + 6 - nh) && (k <= lo + 5);
          end
        end else cmp = 1'b0;
      end
      forever begin
        @(negedge clk);
        if (valid === 1'b1) begin
          n_valid++;
          if (exp_res.size() == 0) chk("unexpected_valid", 1, 0);
          else begin
            chk("result", int'(result), exp_res.pop_front());
            chk("result_ch", int'(result_ch), exp_ch.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_cmp_p2", int'(cmp_p2), 1);
    chk("rst_outs", int'({PI1, PI2, PII1, PII2, PA, PB, PC, PD, src_n, snk, cmp_p1, preChrg,
                          setupBias, ch_onehot, busy, result, result_ch, valid}), 0);
    reset = 1'b1;

    // Single channel: three cmp-high cycles, one H and one L charge.
    ch_en = 4'b0001; cont = 1'b0; base = 3; mode = 0;
    snap();
    exp_res.push_back(3); exp_ch.push_back(0);
    pulse_start();
    wait_valid(v0 + 1, 1000);
    wait_idle(50);
    chk("t1_prechg_len", prechg_cyc - p0, 11);
    chk("t1_diode_cyc", diode_cyc - d0, 2);
    chk("t1_setup_bd_cyc", sb_bd_cyc - s0, 6);
    chk("t1_hcharge", hch_cyc - h0, 1);
    chk("t1_lcharge", lch_cyc - l0, 1);
    chk("t1_out_len", out_cyc - o0, 63);

    // Sparse mask, single pass.
    ch_en = 4'b1010; cont = 1'b0; base = 1;
    snap();
    exp_res.push_back(2); exp_ch.push_back(1);
    exp_res.push_back(4); exp_ch.push_back(3);
    pulse_start();
    wait_valid(v0 + 2, 1500);
    wait_idle(50);
    chk("t2_oh_count", oh_log.size(), 2);
    if (oh_log.size() == 2) begin
      chk("t2_oh_first", oh_log[0], 2);
      chk("t2_oh_second", oh_log[1], 8);
    end
    chk("t2_prechg_len", prechg_cyc - p0, 11);

    // Continuous scan, mask cleared during the fourth OUTPUT.
    ch_en = 4'b0101; cont = 1'b1; base = 1;
    snap();
    for (int i = 0; i < 2; i++) begin
      exp_res.push_back(1); exp_ch.push_back(0);
      exp_res.push_back(3); exp_ch.push_back(2);
    end
    pulse_start();
    wait_valid(v0 + 3, 2500);
    begin
      int c = 0;
      while (!(PA && PB && PC && PD) && c < 500) begin
        @(negedge clk);
        c++;
      end
      chk("t3_out_seen", int'(PA && PB && PC && PD), 1);
    end
    ch_en = 4'b0000;
    wait_valid(v0 + 4, 500);
    wait_idle(50);
    repeat (150) @(negedge clk);
    chk("t3_valid_total", n_valid - v0, 4);
    chk("t3_prechg_len", prechg_cyc - p0, 11);
    chk("t3_idle", int'(busy), 0);
    cont = 1'b0;

    // Saturation: 80 cmp-high BIGDIODE cycles clip to 63.
    ch_en = 4'b0001; mode = 1;
    snap();
    exp_res.push_back(63); exp_ch.push_back(0);
    pulse_start();
    wait_valid(v0 + 1, 1500);
    wait_idle(50);

    // Reset in the middle of BIGDIODE discards the partial conversion.
    mode = 0; base = 1;
    snap();
    pulse_start();
    begin
      int c = 0;
      while (!PI1 && c < 200) begin
        @(negedge clk);
        c++;
      end
      chk("t5_in_bigdiode", int'(PI1), 1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rst_cmp_p2", int'(cmp_p2), 1);
    chk("t5_rst_outs", int'({PI1, PI2, PII1, PII2, PA, PB, PC, PD, src_n, snk, cmp_p1, preChrg,
                             setupBias, ch_onehot, busy, result, result_ch, valid}), 0);
    reset = 1'b1;
    prev = int'(cmp_p1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_cmp_p1_toggle", int'(cmp_p1), 1 - prev);
      chk("t5_cmp_compl", int'(cmp_p2), 1 - int'(cmp_p1));
      prev = int'(cmp_p1);
    end
    repeat (150) @(negedge clk);
    chk("t5_no_valid", n_valid - v0, 0);
    chk("t5_idle", int'(busy), 0);

    chk("sb_drained", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
